// File: rtl/dsm_cic_decimator_if.sv
// -----------------------------------------------------------------------------
// dsm_cic_decimator_if
// Generic AXI4-Stream style channel (tdata/tvalid/tready) used for both the
// 1-bit DSM input stream and the W-bit PCM output stream of the decimator.
//   W       : tdata width
//   master  : drives tdata/tvalid, receives tready
//   slave   : receives tdata/tvalid, drives tready
// -----------------------------------------------------------------------------
interface dsm_cic_decimator_if #(
   parameter int W = 1
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input  tready);
   modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/dsm_cic_decimator.sv
// -----------------------------------------------------------------------------
// dsm_cic_decimator
// Recovers signed WIDTH-bit PCM samples from a 1-bit delta-sigma bitstream
// with a 3rd-order CIC (sinc^3) decimator, ratio R = 2**DECIM_LOG2, followed
// by power-of-two scaling and saturation.
// Ports:
//   aclk         clock
//   arst_n       synchronous active-low reset
//   s_axis_data  slave stream, 1-bit DSM input (1 = +1, 0 = -1)
//   m_axis_data  master stream, WIDTH-bit signed decimated sample
// -----------------------------------------------------------------------------
module dsm_cic_decimator #(
   parameter int WIDTH      = 16,
   parameter int DECIM_LOG2 = 6,
   parameter int ACC_W      = 3*DECIM_LOG2+2
) (
   input  logic                 aclk,
   input  logic                 arst_n,
   dsm_cic_decimator_if.slave   s_axis_data,
   dsm_cic_decimator_if.master  m_axis_data
);

   localparam int SHIFT = 3*DECIM_LOG2 - (WIDTH-1);
   localparam int EXT_W = ACC_W + WIDTH;

   localparam logic signed [EXT_W-1:0] Y_MAX = {{(EXT_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] Y_MIN = {{(EXT_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      WARM0,
      WARM1,
      RUN
   } warm_t;

   warm_t                  state, state_nxt;
   logic                   load;

   logic [ACC_W-1:0]       i1, i2, i3;
   logic [ACC_W-1:0]       d1, d2, d3;
   logic [DECIM_LOG2-1:0]  cnt;

   logic                   cnt_last, accept, dec_event;
   logic [ACC_W-1:0]       x, i1_new, i2_new, i3_new;
   logic [ACC_W-1:0]       c1, c2, c3;
   logic signed [EXT_W-1:0] c3_ext, y_shift;
   logic [WIDTH-1:0]       y;

   assign cnt_last  = &cnt;
   // Only the window-closing bit needs the output register free.
   assign s_axis_data.tready = ~(m_axis_data.tvalid & ~m_axis_data.tready & cnt_last);
   assign accept    = s_axis_data.tvalid & s_axis_data.tready;
   assign dec_event = accept & cnt_last;

   assign x      = s_axis_data.tdata[0] ? ACC_W'(1) : '1;
   assign i1_new = i1 + x;
   assign i2_new = i2 + i1_new;
   assign i3_new = i3 + i2_new;

   assign c1 = i3_new - d1;
   assign c2 = c1 - d2;
   assign c3 = c2 - d3;

   assign c3_ext = {{WIDTH{c3[ACC_W-1]}}, c3};

   generate
      if (SHIFT >= 0) begin : g_shr
         assign y_shift = c3_ext >>> SHIFT;
      end else begin : g_shl
         assign y_shift = c3_ext <<< (-SHIFT);
      end
   endgenerate

   always_comb begin
      y = y_shift[WIDTH-1:0];
      if (y_shift > Y_MAX) begin
         y = Y_MAX[WIDTH-1:0];
      end else if (y_shift < Y_MIN) begin
         y = Y_MIN[WIDTH-1:0];
      end
   end

   // Warm-up: the first two decimation events only prime the comb delays.
   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         state <= WARM0;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         WARM0: if (dec_event) state_nxt = WARM1;
         WARM1: if (dec_event) state_nxt = RUN;
         RUN:   load = dec_event;
         default: state_nxt = WARM0;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         i1  <= '0;
         i2  <= '0;
         i3  <= '0;
         d1  <= '0;
         d2  <= '0;
         d3  <= '0;
         cnt <= '0;
      end else if (accept) begin
         i1  <= i1_new;
         i2  <= i2_new;
         i3  <= i3_new;
         cnt <= cnt + DECIM_LOG2'(1);
         if (dec_event) begin
            d1 <= i3_new;
            d2 <= c1;
            d3 <= c2;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         m_axis_data.tdata  <= '0;
         m_axis_data.tvalid <= 1'b0;
      end else if (load) begin
         m_axis_data.tdata  <= y;
         m_axis_data.tvalid <= 1'b1;
      end else if (m_axis_data.tready) begin
         m_axis_data.tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_dsm_cic_decimator
// Self-checking bench for dsm_cic_decimator (WIDTH=16, R=64). Expected samples
// come from a direct sinc^3 FIR convolution over the accepted bit history.
// -----------------------------------------------------------------------------
module tb_dsm_cic_decimator;

   localparam int WIDTH      = 16;
   localparam int DECIM_LOG2 = 6;
   localparam int R          = 1 << DECIM_LOG2;
   localparam int HLEN       = 3*R - 2;
   localparam int SHIFT      = 3*DECIM_LOG2 - (WIDTH-1);
   localparam int YMAX       = (1 << (WIDTH-1)) - 1;
   localparam int YMIN       = -(1 << (WIDTH-1));

   logic aclk;
   logic arst_n;

   dsm_cic_decimator_if #(.W(1))     s_if ();
   dsm_cic_decimator_if #(.W(WIDTH)) m_if ();

   dsm_cic_decimator #(
      .WIDTH      (WIDTH),
      .DECIM_LOG2 (DECIM_LOG2)
   ) dut (
      .aclk        (aclk),
      .arst_n      (arst_n),
      .s_axis_data (s_if),
      .m_axis_data (m_if)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_errors = 0;

   // sinc^3 impulse response and model state
   int     h [HLEN];
   int     xs [$];
   int     exp_q [$];
   int     acc_cnt  = 0;
   int     ev_cnt   = 0;
   int     out_count = 0;
   int     exp_v;
   bit     lit_en   = 1'b0;
   int     lit_val  = 0;
   int     mode     = 0;   // m_tready: 0 = always 1, 1 = random, 2 = held 0

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void build_h();
      int b2 [2*R-1];
      for (int n = 0; n < 2*R-1; n++) b2[n] = (n < R) ? n+1 : 2*R-1-n;
      for (int n = 0; n < HLEN; n++) begin
         h[n] = 0;
         for (int k = 0; k < R; k++)
            if (n-k >= 0 && n-k < 2*R-1) h[n] += b2[n-k];
      end
   endfunction

   function automatic void model_accept(input bit b);
      longint c3;
      longint y;
      xs.push_front(b ? 1 : -1);
      if (xs.size() > HLEN) void'(xs.pop_back());
      acc_cnt++;
      if (acc_cnt % R == 0) begin
         ev_cnt++;
         if (ev_cnt >= 3) begin
            c3 = 0;
            for (int j = 0; j < xs.size(); j++) c3 += longint'(h[j]) * longint'(xs[j]);
            if (SHIFT >= 0) y = c3 >>> SHIFT;
            else            y = c3 <<< (-SHIFT);
            if (y > YMAX) y = YMAX;
            if (y < YMIN) y = YMIN;
            exp_q.push_back(int'(y));
         end
      end
   endfunction

   // m_tready driver
   always @(posedge aclk) begin
      #1;
      case (mode)
         0:       m_if.tready = 1'b1;
         1:       m_if.tready = 1'($urandom_range(1, 0));
         default: m_if.tready = 1'b0;
      endcase
   end

   // Compare process: DUT outputs vs model every cycle out of reset
   always @(negedge aclk) begin
      if (!arst_n) begin
         xs.delete();
         exp_q.delete();
         acc_cnt = 0;
         ev_cnt  = 0;
      end else begin
         exp_v = (exp_q.size() != 0) ? 1 : 0;
         chk("m_tvalid", int'(m_if.tvalid), exp_v);
         chk("s_tready", int'(s_if.tready),
             (exp_v == 1 && !m_if.tready && (acc_cnt % R == R-1)) ? 0 : 1);
         if (m_if.tvalid && exp_q.size() != 0) begin
            chk("m_tdata", int'($signed(m_if.tdata)), exp_q[0]);
            if (m_if.tready) begin
               if (lit_en) chk("m_tdata_literal", int'($signed(m_if.tdata)), lit_val);
               void'(exp_q.pop_front());
               out_count++;
            end
         end
         if (s_if.tvalid && s_if.tready) model_accept(s_if.tdata[0]);
      end
   end

   function automatic bit pat(input int kind, input int i);
      case (kind)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (i % 2 == 0);
         3:       return (i % 4 != 3);
         default: return 1'($urandom_range(1, 0));
      endcase
   endfunction

   task automatic feed(input int kind, input int nbits, input int vprob);
      bit b;
      bit accepted;
      int waited;
      for (int i = 0; i < nbits; i++) begin
         b        = pat(kind, i);
         accepted = 1'b0;
         waited   = 0;
         while (!accepted) begin
            @(posedge aclk); #1;
            s_if.tvalid = ($urandom_range(99, 0) < vprob);
            s_if.tdata  = b;
            @(negedge aclk);
            accepted = s_if.tvalid && s_if.tready;
            waited++;
            if (waited > 5000) begin
               chk("feed_timeout", waited, 0);
               @(posedge aclk); #1;
               s_if.tvalid = 1'b0;
               return;
            end
         end
      end
      @(posedge aclk); #1;
      s_if.tvalid = 1'b0;
   endtask

   task automatic drain();
      mode = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge aclk);
         if (exp_q.size() == 0 && !m_if.tvalid) break;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge aclk); #1;
      arst_n      = 1'b0;
      s_if.tvalid = 1'b0;
      lit_en      = 1'b0;
      @(posedge aclk); #1;
      arst_n      = 1'b1;
      out_count   = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_errors++;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n      = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = 1'b0;
      m_if.tready = 1'b1;
      build_h();

      // pin the model's impulse response
      begin
         int s;
         s = 0;
         for (int n = 0; n < HLEN; n++) s += h[n];
         chk("h_sum", s, 262144);
         chk("h_first", h[0], 1);
         chk("h_R_minus_1", h[R-1], 2080);
      end

      repeat (2) @(posedge aclk);
      #1 arst_n = 1'b1;
      @(negedge aclk);
      chk("reset_tvalid", int'(m_if.tvalid), 0);
      chk("reset_tdata", int'($signed(m_if.tdata)), 0);
      chk("reset_tready", int'(s_if.tready), 1);

      // all ones -> positive full scale
      lit_en = 1'b1; lit_val = 32767; mode = 0;
      feed(0, 64*20, 100);
      drain();
      chk("ones_count", out_count, 18);

      // all zeros -> negative full scale, long run
      do_reset();
      lit_en = 1'b1; lit_val = -32768;
      feed(1, 64*302, 100);
      drain();
      chk("zeros_count", out_count, 300);

      // alternating -> zero
      do_reset();
      lit_en = 1'b1; lit_val = 0;
      feed(2, 64*20, 100);
      drain();
      chk("alt_count", out_count, 18);

      // 1,1,1,0 -> half scale, continuous then gappy input
      do_reset();
      lit_en = 1'b1; lit_val = 16384;
      feed(3, 64*20, 100);
      drain();
      chk("p1110_count", out_count, 18);
      do_reset();
      lit_en = 1'b1; lit_val = 16384;
      feed(3, 64*20, 50);
      drain();
      chk("p1110_gappy_count", out_count, 18);

      // random bits, random valid and random downstream ready
      do_reset();
      mode = 1;
      feed(4, 64*40, 70);
      drain();
      chk("random_count", out_count, 38);

      // downstream stall after first sample
      do_reset();
      lit_en = 1'b1; lit_val = 32767; mode = 0;
      fork
         feed(0, 64*6, 100);
         begin
            for (int c = 0; c < 2000; c++) begin
               @(negedge aclk);
               if (out_count >= 1) break;
            end
            chk("hold_first_out", out_count, 1);
            mode = 2;
            repeat (300) @(negedge aclk);
            chk("hold_s_tready", int'(s_if.tready), 0);
            chk("hold_m_tvalid", int'(m_if.tvalid), 1);
            chk("hold_cnt_phase", acc_cnt % R, R-1);
            mode = 0;
         end
      join
      drain();
      chk("hold_count", out_count, 4);

      // reset mid-window with a held sample pending
      do_reset();
      mode = 2;
      feed(4, 64*3+30, 100);
      @(negedge aclk);
      chk("midrst_held", int'(m_if.tvalid), 1);
      chk("midrst_phase", acc_cnt % R, 30);
      do_reset();
      @(negedge aclk);
      chk("midrst_tvalid", int'(m_if.tvalid), 0);
      mode = 0;
      lit_en = 1'b1; lit_val = 32767;
      feed(0, 191, 100);
      repeat (3) @(negedge aclk);
      chk("midrst_no_early", out_count, 0);
      feed(0, 1, 100);
      drain();
      chk("midrst_count", out_count, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
